// File: rtl/conv_output_drain_if.sv
// Bundle for the conv output drain: control, conv output memory read port and output stream.
interface conv_output_drain_if #(
  parameter int unsigned DATA_SIZE = 64
);
  logic                 start;
  logic                 abort;
  logic                 layer_done;
  logic [15:0]          read_outmem_index2;
  logic [15:0]          read_outmem_index1;
  logic [15:0]          read_outmem_index0;
  logic [DATA_SIZE-1:0] outmem_out_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [DATA_SIZE-1:0] m_data;
  logic                 m_last;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, abort, layer_done, outmem_out_data, m_ready,
    output read_outmem_index2, read_outmem_index1, read_outmem_index0,
           m_valid, m_data, m_last, busy, done
  );

  modport slave (
    output start, abort, layer_done, outmem_out_data, m_ready,
    input  read_outmem_index2, read_outmem_index1, read_outmem_index0,
           m_valid, m_data, m_last, busy, done
  );
endinterface

// File: rtl/conv_output_drain.sv
// Walks the conv output memory (x fastest, then y, then entry) and streams each word
// out on a valid/ready port, with optional ReLU on the captured word.
module conv_output_drain #(
  parameter string       NAME         = "CONV_OUTPUT_DRAIN_DEFAULT_NAME",
  parameter int unsigned NUM_OUTPUTS  = 1,
  parameter int unsigned OUTPUT_DIM   = 3,
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned APPLY_RELU   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  conv_output_drain_if.master   bus
);

  localparam int unsigned IDX_W = 16;
  localparam int unsigned LAT_W = 3;
  localparam logic [IDX_W-1:0] XY_MAX  = IDX_W'(OUTPUT_DIM - 1);
  localparam logic [IDX_W-1:0] ENT_MAX = IDX_W'(NUM_OUTPUTS - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY);

  if (READ_LATENCY > 4 || NUM_OUTPUTS == 0 || OUTPUT_DIM == 0) begin : g_param_check
    $error("%s: illegal parameter set", NAME);
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LAYER,
    S_WAIT_DATA,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_idx2, r_idx1, r_idx0;
  logic [IDX_W-1:0]     w_idx2_nxt, w_idx1_nxt, w_idx0_nxt;
  logic [LAT_W-1:0]     r_lat, w_lat_nxt;
  logic [DATA_SIZE-1:0] r_data, w_data_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_last, w_last_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic                 w_at_end;
  logic                 w_hs;
  logic [DATA_SIZE-1:0] w_capt;

  assign w_at_end = (r_idx2 == ENT_MAX) && (r_idx1 == XY_MAX) && (r_idx0 == XY_MAX);
  assign w_hs     = r_valid && bus.m_ready;

  // Negative values and -0.0 both carry the sign bit and collapse to +0.0
  assign w_capt = ((APPLY_RELU != 0) && bus.outmem_out_data[DATA_SIZE-1]) ?
                  '0 : bus.outmem_out_data;

  // Next-state and next-register values
  always_comb begin
    w_state_nxt = r_state;
    w_idx2_nxt  = r_idx2;
    w_idx1_nxt  = r_idx1;
    w_idx0_nxt  = r_idx0;
    w_lat_nxt   = r_lat;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_last_nxt  = r_last;

    if (bus.abort) begin
      w_state_nxt = S_IDLE;
      w_idx2_nxt  = '0;
      w_idx1_nxt  = '0;
      w_idx0_nxt  = '0;
      w_lat_nxt   = '0;
      w_valid_nxt = 1'b0;
      w_last_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            w_state_nxt = S_WAIT_LAYER;
            w_idx2_nxt  = '0;
            w_idx1_nxt  = '0;
            w_idx0_nxt  = '0;
          end
        end
        S_WAIT_LAYER: begin
          if (bus.layer_done) begin
            w_state_nxt = S_WAIT_DATA;
            w_lat_nxt   = LAT_LOAD;
          end
        end
        S_WAIT_DATA: begin
          if (r_lat == '0) begin
            w_state_nxt = S_PRESENT;
            w_data_nxt  = w_capt;
            w_valid_nxt = 1'b1;
            w_last_nxt  = w_at_end;
          end else begin
            w_lat_nxt = r_lat - LAT_W'(1);
          end
        end
        S_PRESENT: begin
          if (w_hs) begin
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            if (r_last) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_WAIT_DATA;
              w_lat_nxt   = LAT_LOAD;
              if (r_idx0 == XY_MAX) begin
                w_idx0_nxt = '0;
                if (r_idx1 == XY_MAX) begin
                  w_idx1_nxt = '0;
                  w_idx2_nxt = r_idx2 + IDX_W'(1);
                end else begin
                  w_idx1_nxt = r_idx1 + IDX_W'(1);
                end
              end else begin
                w_idx0_nxt = r_idx0 + IDX_W'(1);
              end
            end
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
          w_last_nxt  = 1'b0;
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx2  <= '0;
      r_idx1  <= '0;
      r_idx0  <= '0;
      r_lat   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx2  <= w_idx2_nxt;
      r_idx1  <= w_idx1_nxt;
      r_idx0  <= w_idx0_nxt;
      r_lat   <= w_lat_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.read_outmem_index2 = r_idx2;
  assign bus.read_outmem_index1 = r_idx1;
  assign bus.read_outmem_index0 = r_idx0;
  assign bus.m_valid            = r_valid;
  assign bus.m_data             = r_data;
  assign bus.m_last             = r_last;
  assign bus.busy               = r_busy;
  assign bus.done               = r_done;

endmodule
